// File: rtl/mlp_pkg.sv
// Shared constants, state encoding and rescale/saturate helper for the
// time-multiplexed neuron sequencer.
package mlp_pkg;

    localparam int QM_D = 12;
    localparam int QN_D = 20;
    localparam int WM_D = 6;
    localparam int WN_D = 10;
    localparam int G_D  = 2;

    localparam int SAT_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int acc_width(input int qm, input int qn,
                                     input int wm, input int wn,
                                     input int g);
        return qm + qn + wm + wn + g;
    endfunction

    // Works on a wide sign-extended copy so any ACC_W/OUT_W pair fits.
    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] a,
        input int                      wn,
        input int                      out_w
    );
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] mx;
        logic signed [SAT_W-1:0] mn;
        one = 1;
        s   = a >>> wn;
        mx  = (one <<< (out_w - 1)) - one;
        mn  = ~mx;
        if (s > mx)
            return mx;
        else if (s < mn)
            return mn;
        return s;
    endfunction

endpackage

// File: rtl/mac_seq_sat.sv
// Combinational rescale + saturate of the accumulator sum.
// Define MAC_SEQ_RELU_EN to clamp negative results to zero.
module mac_seq_sat
    import mlp_pkg::*;
#(
    parameter int ACC_W = 50,
    parameter int OUT_W = 32,
    parameter int WN    = 10
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] res_o
);

    logic signed [SAT_W-1:0] ext;
    logic signed [SAT_W-1:0] sat;
    logic                    unused_hi;

    assign ext       = {{(SAT_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
    assign sat       = sat_shift(ext, WN, OUT_W);
    assign unused_hi = ^sat[SAT_W-1:OUT_W];

    always_comb begin
        res_o = sat[OUT_W-1:0];
`ifdef MAC_SEQ_RELU_EN
        if (res_o[OUT_W-1])
            res_o = '0;
`else
        res_o = res_o;
`endif
    end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one time-multiplexed neuron: reads, accumulates, rescales.
// Optional ReLU on the result via MAC_SEQ_RELU_EN (see mac_seq_sat).
module mac_seq_ctrl
    import mlp_pkg::*;
#(
    parameter  int N_IN  = 4,
    parameter  int QM    = QM_D,
    parameter  int QN    = QN_D,
    parameter  int WM    = WM_D,
    parameter  int WN    = WN_D,
    parameter  int G     = G_D,
    localparam int ACC_W = acc_width(QM, QN, WM, WN, G),
    localparam int OUT_W = QM + QN,
    localparam int AW    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic                    abort,
    output logic                    rd_en,
    output logic [AW-1:0]           rd_addr,
    input  logic signed [ACC_W-1:0] mac_out,
    output logic signed [ACC_W-1:0] acc,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic signed [OUT_W-1:0] result_data,
    output logic                    busy
);

    localparam logic [AW-1:0] LAST = AW'(N_IN - 1);

    state_e                  state_q, state_d;
    logic                    rd_en_q, acc_en_q, rv_q;
    logic [AW-1:0]           addr_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [OUT_W-1:0] res_q, sat_res;
    logic                    start_acc, res_hs, last_acc;

    mac_seq_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .WN    (WN)
    ) u_sat (
        .acc_i (mac_out),
        .res_o (sat_res)
    );

    always_comb begin
        start_ready = (state_q == IDLE) ||
                      (state_q == DONE && result_ready);
        busy        = (state_q != IDLE);
    end

    assign start_acc = start_valid && start_ready && !abort;
    assign res_hs    = rv_q && result_ready;
    assign last_acc  = (state_q == RUN) && acc_en_q && !rd_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_acc) state_d = RUN;
            RUN:  if (last_acc) state_d = DONE;
            DONE: begin
                if (start_acc)
                    state_d = RUN;
                else if (result_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort)
            state_d = IDLE;
    end

    // Read strobe leads the accumulate by one cycle (buffer read latency).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            rd_en_q  <= 1'b0;
            acc_en_q <= 1'b0;
            addr_q   <= '0;
            rv_q     <= 1'b0;
            res_q    <= '0;
        end else if (abort) begin
            acc_q    <= '0;
            rd_en_q  <= 1'b0;
            acc_en_q <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            acc_en_q <= rd_en_q;
            if (start_acc) begin
                acc_q   <= '0;
                rd_en_q <= 1'b1;
                addr_q  <= '0;
            end else begin
                if (acc_en_q)
                    acc_q <= mac_out;
                if (rd_en_q) begin
                    if (addr_q == LAST)
                        rd_en_q <= 1'b0;
                    else
                        addr_q <= addr_q + AW'(1);
                end
            end
            if (last_acc) begin
                rv_q  <= 1'b1;
                res_q <= sat_res;
            end else if (res_hs) begin
                rv_q <= 1'b0;
            end
        end
    end

    assign rd_en        = rd_en_q;
    assign rd_addr      = addr_q;
    assign acc          = acc_q;
    assign result_valid = rv_q;
    assign result_data  = res_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomised self-checking bench for mac_seq_ctrl with a behavioural
// buffer/MAC model and a sum-of-products reference.
module tb_mac_seq_ctrl;

    localparam int N     = 4;
    localparam int ACC_W = 50;
    localparam int OUT_W = 32;
    localparam int AW    = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start_valid, start_ready, abort;
    logic                    rd_en;
    logic [AW-1:0]           rd_addr;
    logic signed [ACC_W-1:0] mac_out, acc;
    logic                    result_valid, result_ready;
    logic signed [OUT_W-1:0] result_data;
    logic                    busy;

    logic signed [31:0] in_mem [N];
    logic signed [15:0] w_mem  [N];
    logic signed [31:0] op_in;
    logic signed [15:0] op_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_seq_ctrl #(.N_IN(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .abort        (abort),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .mac_out      (mac_out),
        .acc          (acc),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data),
        .busy         (busy)
    );

    // Buffers present operands one cycle after the read strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_in <= '0;
            op_w  <= '0;
        end else if (rd_en) begin
            op_in <= in_mem[rd_addr];
            op_w  <= w_mem[rd_addr];
        end
    end

    assign mac_out = ACC_W'(longint'(op_in) * longint'(op_w) + longint'(acc));

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic signed [31:0] ref_out();
        longint sum, lim;
        logic signed [31:0] r;
        sum = 0;
        for (int i = 0; i < N; i++)
            sum += longint'(in_mem[i]) * longint'(w_mem[i]);
        sum = sum >>> 10;
        lim = longint'(1) << 31;
        if (sum > lim - 1)
            r = 32'sh7FFFFFFF;
        else if (sum < -lim)
            r = 32'sh80000000;
        else
            r = sum[31:0];
`ifdef MAC_SEQ_RELU_EN
        if (r < 0)
            r = 0;
`endif
        return r;
    endfunction

    task automatic set_all(input logic signed [31:0] x,
                           input logic signed [15:0] w);
        for (int i = 0; i < N; i++) begin
            in_mem[i] = x;
            w_mem[i]  = w;
        end
    endtask

    task automatic kick();
        @(negedge clk);
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    // Starts right after an accept edge; waits for and checks the result.
    task automatic collect(input string tag, input logic signed [31:0] exp,
                           input bit do_hs);
        int c, nrd;
        bit got;
        logic signed [31:0] held;
        c = 0; nrd = 0; got = 0;
        while (c < 20 && !got) begin
            @(negedge clk);
            c++;
            if (rd_en) nrd++;
            if (result_valid) got = 1;
        end
        chk({tag, ".lat"}, 64'(c), 64'(N + 2));
        chk({tag, ".rd"}, 64'(nrd), 64'(N));
        chk({tag, ".data"}, 64'(result_data), 64'(exp));
        held = result_data;
        if (do_hs) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk({tag, ".hold"}, 64'(result_data), 64'(held));
            end
            @(negedge clk);
            result_ready = 1'b1;
            @(posedge clk);
            #1 result_ready = 1'b0;
            chk({tag, ".rvclr"}, 64'(result_valid), 64'(0));
        end
    endtask

    task automatic neuron(input string tag, input logic signed [31:0] exp);
        kick();
        collect(tag, exp, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [31:0] e;
        logic signed [31:0] held;
        int seen;
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        abort        = 1'b0;
        result_ready = 1'b0;
        set_all(0, 0);
        #2;
        chk("rst.acc", 64'(acc), 64'(0));
        chk("rst.rd_en", 64'(rd_en), 64'(0));
        chk("rst.rv", 64'(result_valid), 64'(0));
        chk("rst.data", 64'(result_data), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst.sready", 64'(start_ready), 64'(1));
        chk("rst.busy", 64'(busy), 64'(0));

        set_all(32'sh00100000, 16'sh0200);
        neuron("ones", 32'sh00200000);

        in_mem[0] = 32'sh00100000; w_mem[0] = 16'sh0400;
        in_mem[1] = -32'sh00100000; w_mem[1] = 16'sh0400;
        in_mem[2] = 32'sh00200000; w_mem[2] = -16'sh0200;
        in_mem[3] = 0;              w_mem[3] = 16'sh0400;
`ifdef MAC_SEQ_RELU_EN
        neuron("mixed", 32'sh0);
`else
        neuron("mixed", 32'shFFF00000);
`endif

        set_all(32'sh7FF00000, 16'sh7C00);
        neuron("satpos", 32'sh7FFFFFFF);
        set_all(32'sh7FF00000, -16'sh7C00);
`ifdef MAC_SEQ_RELU_EN
        neuron("satneg", 32'sh0);
`else
        neuron("satneg", 32'sh80000000);
`endif

        // Backpressure, ignored start, then back-to-back handshake.
        set_all(32'sh00100000, 16'sh0200);
        kick();
        collect("bp", 32'sh00200000, 1'b0);
        held = result_data;
        start_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp.hold", 64'(result_data), 64'(held));
            chk("bp.sready", 64'(start_ready), 64'(0));
            chk("bp.rd_en", 64'(rd_en), 64'(0));
        end
        for (int i = 0; i < N; i++) begin
            in_mem[i] = 32'sh00100000 * (i + 1);
            w_mem[i]  = 16'sh0400;
        end
        e = ref_out();
        result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
        start_valid = 1'b0;
        chk("b2b.rv", 64'(result_valid), 64'(0));
        chk("b2b.acc", 64'(acc), 64'(0));
        chk("b2b.rd_en", 64'(rd_en), 64'(1));
        chk("b2b.addr", 64'(rd_addr), 64'(0));
        chk("b2b.busy", 64'(busy), 64'(1));
        collect("b2b", e, 1'b1);

        // Abort in the second run cycle.
        kick();
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort.busy", 64'(busy), 64'(0));
        chk("abort.acc", 64'(acc), 64'(0));
        chk("abort.rd_en", 64'(rd_en), 64'(0));
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        chk("abort.norv", 64'(seen), 64'(0));
        for (int i = 0; i < N; i++) begin
            in_mem[i] = $signed($urandom) >>> 12;
            w_mem[i]  = 16'($urandom);
        end
        neuron("post_abort", ref_out());

        // Asynchronous reset mid-run.
        set_all(32'sh00300000, 16'sh0400);
        kick();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.acc", 64'(acc), 64'(0));
        chk("arst.rd_en", 64'(rd_en), 64'(0));
        chk("arst.addr", 64'(rd_addr), 64'(0));
        chk("arst.rv", 64'(result_valid), 64'(0));
        chk("arst.data", 64'(result_data), 64'(0));
        chk("arst.busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arst.sready", 64'(start_ready), 64'(1));
        neuron("post_rst", ref_out());

        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < N; i++) begin
                in_mem[i] = $signed($urandom) >>> $urandom_range(0, 16);
                w_mem[i]  = 16'($urandom);
            end
            neuron("rand", ref_out());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
